// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, bubble-clearing control field,
// synchronous flush, saturating back-pressure counter. Define PIPE_STAGE_SKID_EN for a registered-ready skid entry.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned DATA_W = 165,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_out_valid;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic [DATA_W-1:0] w_out_data;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic              w_accept;
    logic              w_out_free;

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

    assign w_accept   = in_valid & in_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    // Back-pressure counter: saturates, cleared only by reset
    always_comb begin
        w_stall_cnt = r_stall_cnt;
        if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            w_stall_cnt = r_stall_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    // Ready depends only on registered skid occupancy, breaking the out_ready -> in_ready path
    assign in_ready = ~r_skid_valid;

    // Next-state for output and skid entries; skid drains first so ordering stays FIFO
    always_comb begin
        w_out_valid  = r_out_valid;
        w_out_ctrl   = r_out_ctrl;
        w_out_data   = r_out_data;
        w_skid_valid = r_skid_valid;
        w_skid_ctrl  = r_skid_ctrl;
        w_skid_data  = r_skid_data;

        if (flush) begin
            w_out_valid  = 1'b0;
            w_out_ctrl   = '0;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_valid  = 1'b1;
                w_out_ctrl   = r_skid_ctrl;
                w_out_data   = r_skid_data;
                w_skid_valid = 1'b0;
                w_skid_ctrl  = '0;
            end else if (w_accept) begin
                w_out_valid = 1'b1;
                w_out_ctrl  = in_ctrl;
                w_out_data  = in_data;
            end else begin
                w_out_valid = 1'b0;
                w_out_ctrl  = '0;
            end
        end else if (w_accept) begin
            w_skid_valid = 1'b1;
            w_skid_ctrl  = in_ctrl;
            w_skid_data  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_out_data   <= '0;
            r_stall_cnt  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid;
            r_out_ctrl   <= w_out_ctrl;
            r_out_data   <= w_out_data;
            r_stall_cnt  <= w_stall_cnt;
            r_skid_valid <= w_skid_valid;
            r_skid_ctrl  <= w_skid_ctrl;
            r_skid_data  <= w_skid_data;
        end
    end

`else

    // Single entry: room exists when empty or when the current entry leaves this cycle
    assign in_ready = w_out_free;

    // Output next-state: load on accept, bubble on consume-only, hold under back-pressure
    always_comb begin
        w_out_valid = r_out_valid;
        w_out_ctrl  = r_out_ctrl;
        w_out_data  = r_out_data;

        if (flush) begin
            w_out_valid = 1'b0;
            w_out_ctrl  = '0;
        end else if (w_accept) begin
            w_out_valid = 1'b1;
            w_out_ctrl  = in_ctrl;
            w_out_data  = in_data;
        end else if (w_out_free) begin
            w_out_valid = 1'b0;
            w_out_ctrl  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_out_data  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_out_valid <= w_out_valid;
            r_out_ctrl  <= w_out_ctrl;
            r_out_data  <= w_out_data;
            r_stall_cnt <= w_stall_cnt;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 9;
    localparam int unsigned DW = 165;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of entries; the head is what the output must show
    logic [CW-1:0] mq_ctrl[$];
    logic [DW-1:0] mq_data[$];
    logic [DW-1:0] m_data  = '0;
    int            m_cnt   = 0;
    bit            m_known = 1'b0;

    function automatic bit m_in_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return mq_ctrl.size() < 2;
`else
        return (mq_ctrl.size() == 0) || (ordy == 1'b1);
`endif
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit cons;
        if (reset) begin
            mq_ctrl.delete();
            mq_data.delete();
            m_data  = '0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            acc  = in_valid && m_in_ready(out_ready);
            cons = (mq_ctrl.size() > 0) && out_ready;
            if ((mq_ctrl.size() > 0) && !out_ready && (m_cnt < (1 << NW) - 1)) m_cnt++;
            if (flush) begin
                mq_ctrl.delete();
                mq_data.delete();
            end else begin
                if (cons) begin
                    void'(mq_ctrl.pop_front());
                    void'(mq_data.pop_front());
                end
                if (acc) begin
                    mq_ctrl.push_back(in_ctrl);
                    mq_data.push_back(in_data);
                end
            end
            if (mq_ctrl.size() > 0) m_data = mq_data[0];
        end
    end

    always @(negedge clk) begin : compare
        if (m_known) begin
            chk("cmp_out_valid", 192'(out_valid), 192'(mq_ctrl.size() > 0));
            chk("cmp_out_ctrl", 192'(out_ctrl), (mq_ctrl.size() > 0) ? 192'(mq_ctrl[0]) : 192'(0));
            chk("cmp_out_data", 192'(out_data), 192'(m_data));
            chk("cmp_stall_cnt", 192'(stall_cnt), 192'(m_cnt));
            chk("cmp_in_ready", 192'(in_ready), 192'(m_in_ready(out_ready)));
        end
    end

    task automatic drv(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  seq;
        bit  pending;
        bit  acc;
        logic v;
        logic ordy;

        reset = 1'b1;
        flush = 1'b0;
        drv(1'b1, 9'h1FF, DW'(32'h5A), 1'b0);
        step();
        step();
        chk("reset_valid", 192'(out_valid), 192'(0));
        chk("reset_ctrl", 192'(out_ctrl), 192'(0));
        chk("reset_data", 192'(out_data), 192'(0));
        chk("reset_stall", 192'(stall_cnt), 192'(0));
        reset = 1'b0;
        drv(1'b0, '0, '0, 1'b1);
        step();
        chk("reset_in_ready", 192'(in_ready), 192'(1));

        // Streaming 1..4 at full throughput
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, CW'(i), DW'(i), 1'b1);
            step();
            chk("stream_valid", 192'(out_valid), 192'(1));
            chk("stream_data", 192'(out_data), 192'(i));
        end
        drv(1'b0, '0, '0, 1'b1);
        step();
        chk("stream_end_valid", 192'(out_valid), 192'(0));

        // Stall with B6 offered
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(1'b1, 9'h011, DW'(32'hA5), 1'b1);
        step();
        chk("stall_load", 192'(out_data), 192'(32'hA5));
        drv(1'b1, 9'h022, DW'(32'hB6), 1'b0);
        repeat (3) step();
        chk("stall_hold_data", 192'(out_data), 192'(32'hA5));
        chk("stall_hold_valid", 192'(out_valid), 192'(1));
        chk("stall_cnt3", 192'(stall_cnt), 192'(3));
        chk("stall_in_ready", 192'(in_ready), 192'(0));
        out_ready = 1'b1;
        step();
        chk("stall_release_data", 192'(out_data), 192'(32'hB6));
        chk("stall_release_ctrl", 192'(out_ctrl), 192'(9'h022));
        drv(1'b0, '0, '0, 1'b1);
        step();
        chk("stall_drain_valid", 192'(out_valid), 192'(0));

        // Bubble keeps data, clears control
        drv(1'b1, 9'h0C3, DW'(32'h77), 1'b1);
        step();
        chk("bubble_load_ctrl", 192'(out_ctrl), 192'(9'h0C3));
        drv(1'b0, '0, '0, 1'b1);
        step();
        chk("bubble_valid", 192'(out_valid), 192'(0));
        chk("bubble_ctrl", 192'(out_ctrl), 192'(0));
        chk("bubble_data", 192'(out_data), 192'(32'h77));

        // Flush beats a concurrent accept
        drv(1'b1, 9'h055, DW'(32'h33), 1'b0);
        step();
        chk("flush_pre_data", 192'(out_data), 192'(32'h33));
        flush = 1'b1;
        drv(1'b1, 9'h1FF, DW'(32'h99), 1'b0);
        step();
        flush = 1'b0;
        chk("flush_valid", 192'(out_valid), 192'(0));
        chk("flush_ctrl", 192'(out_ctrl), 192'(0));
        chk("flush_data_hold", 192'(out_data), 192'(32'h33));
        drv(1'b0, '0, '0, 1'b1);
        step();
        step();
        chk("flush_never_valid", 192'(out_valid), 192'(0));
        chk("flush_never_data", 192'(out_data), 192'(32'h33));

        // Mixed traffic with back-pressure; upstream holds an entry until taken
        seq     = 1;
        pending = 1'b0;
        for (int i = 0; i < 24; i++) begin
            v    = pending || ((i % 3) != 2);
            ordy = ((i % 4) != 1);
            drv(v, CW'(seq), DW'(seq * 3 + 1), ordy);
            acc = v && m_in_ready(ordy);
            step();
            if (acc) seq++;
            pending = v && !acc;
        end
        drv(1'b0, '0, '0, 1'b1);
        repeat (3) step();

        // Saturation at 2^NW-1
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(1'b1, 9'h0AA, DW'(5), 1'b1);
        step();
        drv(1'b0, '0, '0, 1'b0);
        repeat (14) step();
        chk("sat_cnt14", 192'(stall_cnt), 192'(14));
        repeat (6) step();
        chk("sat_cnt15", 192'(stall_cnt), 192'(15));
        chk("sat_data", 192'(out_data), 192'(5));

        // Reset mid-stall
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_cnt", 192'(stall_cnt), 192'(0));
        chk("midreset_valid", 192'(out_valid), 192'(0));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the 5-stage core, generalising the fixed ID/EX latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field, which is zeroed whenever a bubble is produced, and a data field, which holds its value on bubbles. The stage uses a valid/ready handshake in place of a bare stall input, supports a synchronous flush for branch squash, and counts back-pressure cycles. An optional skid buffer registers the upstream ready path.

## Interface
- CTRL_W, default 9: width of the control field (RegWrite, MemtoReg, Branch, MemRead, MemWrite, ALUSrc, ALUOp[1:0], spare); cleared on bubble.
- DATA_W, default 165: width of the payload field (PC, rs1/rs2 data, imm, Rs1/Rs2/Rd); held on bubble.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: squash all held entries; takes priority over load.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage accepts an entry this cycle.
- in_ctrl, in, CTRL_W: upstream control field.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: output entry present.
- out_ready, in, 1: downstream consumes the entry this cycle.
- out_ctrl, out, CTRL_W: registered control; all-zero whenever out_valid=0.
- out_data, out, DATA_W: registered payload.
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- reset: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid state empty. in_ready=1 the cycle after reset deasserts.
- flush (reset=0): out_valid=0, out_ctrl=0, skid entry invalidated. out_data holds. Any accept in the same cycle is discarded. stall_cnt is unaffected.
- Base mode (no skid): in_ready = ~out_valid | out_ready, which is combinational from out_ready.
  - accept: out_valid=1, out_ctrl=in_ctrl, out_data=in_data.
  - consume without accept: out_valid=0, out_ctrl=0 (bubble), out_data holds.
  - out_valid & ~out_ready: every output holds.
- stall_cnt increments by 1 in each cycle where out_valid & ~out_ready, saturating at 2^CNT_W-1. It never wraps. It is cleared only by reset.
- Control and data are always captured together from the same entry. No field from one entry is ever mixed with a field from a neighbouring entry.

## Timing
- Latency: exactly 1 cycle from accept to out_valid=1, in both modes.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Priority, highest first: reset > flush > accept/consume > hold.
- Simultaneous accept and consume in the same cycle: the new entry replaces the old one. out_valid stays 1 and no bubble is inserted.
- in_valid=1 with in_ready=0: the entry is not taken. Upstream must hold in_ctrl/in_data stable until the entry is accepted.
- Reset asserted mid-stall: all outputs are at their reset values on the next edge, and stall_cnt=0.

## Configuration
- PIPE_STAGE_SKID_EN defined: a second (skid) entry is added, and in_ready becomes registered as in_ready = ~skid_valid.
  - An accept while out_valid & ~out_ready writes the skid entry.
  - On consume, the skid entry moves to the output register in the same edge. In that edge, a concurrent accept writes the skid entry only if the skid was already occupied; since the skid is empty whenever accept is possible, a concurrent accept goes to the output register, behind nothing.
  - Ordering is strictly FIFO.
  - flush clears both entries.
  - Latency remains 1 cycle when the output is free.
- PIPE_STAGE_SKID_EN undefined: the single-register behaviour described above, with no skid storage.

## Test plan
- Reset: reset=1 for 2 cycles with in_valid=1, in_ctrl=9'h1FF → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0; in_ready=1 after release.
- Streaming: out_ready=1, one entry per cycle with data 1,2,3,4 → out_data 1,2,3,4 on consecutive cycles each one cycle after accept, out_valid continuously 1.
- Stall: load data=A5, then out_ready=0 for 3 cycles while offering B6 → out_data=A5 held, stall_cnt=3.
  - Base mode: in_ready=0 during the stall; B6 appears one cycle after out_ready returns to 1.
  - Skid mode: B6 is accepted once; after release the order is A5, B6.
- Bubble: single entry with ctrl=9'h0C3, then in_valid=0 with out_ready=1 → the next cycle has out_valid=0, out_ctrl=0, out_data unchanged.
- Flush vs accept: flush=1 together with in_valid=1 and ctrl=9'h1FF while one entry is held → next cycle out_valid=0, out_ctrl=0, and that entry never appears.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
